// File: rtl/alu_pipe.sv
// Handshaked N-bit ALU with registered result/flags and an iterative
// shift-add unsigned multiplier that stalls the producer while it runs.
module alu_pipe #(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  input  logic [2:0]   operation,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         Z,
  output logic         C,
  output logic         V,
  output logic         N_flag,
  output logic         busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_nxt;

  logic           accept;
  logic           accept_mul;
  logic [N-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;

  logic [2*N-1:0] mcand_p0;
  logic [N-1:0]   mplier_p0;
  logic [2*N-1:0] acc_p0;
  logic [SHW-1:0] cnt_p0;
  logic [2*N-1:0] acc_nxt;
  logic           mul_last;

  function automatic logic add_ovf(input logic signed [N-1:0] x,
                                   input logic signed [N-1:0] y,
                                   input logic signed [N-1:0] s);
    return (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [N-1:0] x,
                                   input logic signed [N-1:0] y,
                                   input logic signed [N-1:0] d);
    return (x[N-1] != y[N-1]) && (d[N-1] != x[N-1]);
  endfunction

  // Returns {carry, overflow, result} for every single-cycle operation.
  function automatic logic [N+1:0] alu_eval(input logic [2:0]   op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N:0]     ext;
    logic [N-1:0]   res;
    logic           c;
    logic           v;
    logic [SHW-1:0] sh;
    ext = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    sh  = b[SHW-1:0];
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        res = ext[N-1:0];
        c   = ext[N];
        v   = add_ovf(a, b, res);
      end
      OP_SUB: begin
        ext = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        res = ext[N-1:0];
        c   = ext[N];
        v   = sub_ovf(a, b, res);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      // The extra bit on each side catches the last bit shifted out.
      OP_LSL: begin
        ext = {1'b0, a} << sh;
        res = ext[N-1:0];
        c   = ext[N];
      end
      OP_LSR: begin
        ext = {a, 1'b0} >> sh;
        res = ext[N:1];
        c   = ext[0];
      end
      default: res = '0;
    endcase
    return {c, v, res};
  endfunction

  assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign accept_mul = accept && (operation == OP_MUL);
  assign busy       = (state == MUL);

  assign {alu_c, alu_v, alu_res} = alu_eval(operation, SrcA, SrcB);

  assign acc_nxt  = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign mul_last = (state == MUL) && (cnt_p0 == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mul) state_nxt = MUL;
      MUL:     if (mul_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- p0: operand capture / multiply iteration -> output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
      N_flag    <= 1'b0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p0    <= '0;
      cnt_p0    <= '0;
    end else if (accept_mul) begin
      mcand_p0  <= {{N{1'b0}}, SrcA};
      mplier_p0 <= SrcB;
      acc_p0    <= '0;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      result    <= alu_res;
      Z         <= (alu_res == '0);
      C         <= alu_c;
      V         <= alu_v;
      N_flag    <= alu_res[N-1];
      out_valid <= 1'b1;
    end else if (state == MUL) begin
      acc_p0    <= acc_nxt;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + 1'b1;
      if (mul_last) begin
        result    <= acc_nxt[N-1:0];
        Z         <= (acc_nxt[N-1:0] == '0);
        C         <= |acc_nxt[2*N-1:N];
        V         <= 1'b0;
        N_flag    <= acc_nxt[N-1];
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are queued at acceptance
// and compared when the DUT hands a result to the consumer.
module tb_alu_pipe;
  localparam int N = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LSL = 3'b101;
  localparam logic [2:0] LSR = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] SrcA = '0;
  logic [N-1:0] SrcB = '0;
  logic [2:0]   operation = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         Z, C, V, N_flag, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [N+3:0] sb_q[$];
  logic rnd_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .Z(Z), .C(C), .V(V), .N_flag(N_flag), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference packed as {result, Z, C, V, N_flag}.
  function automatic logic [N+3:0] model(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    int sa, sb, s, sh;
    logic [N-1:0] r;
    logic [2*N-1:0] p;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % N);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      ADD: begin
        s = int'(a) + int'(b);
        r = a + b;
        c = (s >= (1 << N));
        s = sa + sb;
        v = (s > (1 << (N-1)) - 1) || (s < -(1 << (N-1)));
      end
      SUB: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > (1 << (N-1)) - 1) || (s < -(1 << (N-1)));
      end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      LSL: begin r = a << sh; c = (sh != 0) ? a[N-sh] : 1'b0; end
      LSR: begin r = a >> sh; c = (sh != 0) ? a[sh-1] : 1'b0; end
      default: begin p = a * b; r = p[N-1:0]; c = (p[2*N-1:N] != 0); end
    endcase
    return {r, (r == '0), c, v, r[N-1]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected", 32'(sb_q.size()), 32'd1);
        else check("sb_result", 32'({result, Z, C, V, N_flag}), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(model(operation, SrcA, SrcB));
    end
  end

  // Holds the request until accepted, returns 1 time unit after the accept edge.
  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic acc;
    acc = 1'b0;
    operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1'b1; break; end
    end
    check("accept", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string tag, input logic [N-1:0] r,
                            input logic z, input logic c, input logic v, input logic n);
    check(tag, 32'({result, Z, C, V, N_flag}), 32'({r, z, c, v, n}));
  endtask

  initial begin
    logic [N+3:0] snap;
    int k, busy_cnt, c0, stale;

    repeat (2) @(posedge clk); #1;
    check("rst_outs", 32'({out_valid, busy, result, Z, C, V, N_flag}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send(ADD, 8'h7F, 8'h01);
    check("add_latency", 32'(out_valid), 32'd1);
    expect_now("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    send(SUB, 8'h05, 8'h05);
    expect_now("sub_5_5", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    send(SUB, 8'h03, 8'h05);
    expect_now("sub_3_5", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    send(ADD, 8'hFF, 8'h01);
    expect_now("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    send(LSL, 8'h81, 8'h01);
    expect_now("lsl_81_1", 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    send(LSR, 8'h01, 8'h01);
    expect_now("lsr_01_1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    send(LSL, 8'hA5, 8'h08);
    expect_now("lsl_amt0", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);

    // Multiply: count busy cycles and edges until the result appears.
    send(MUL, 8'h10, 8'h20);
    k = 0; busy_cnt = 0;
    while (!out_valid && k < 30) begin
      check("mul_in_ready", 32'(in_ready), 32'd0);
      busy_cnt += int'(busy);
      @(posedge clk); #1;
      k++;
    end
    check("mul_latency", 32'(k + 1), 32'(N + 1));
    check("mul_busy_cycles", 32'(busy_cnt), 32'(N));
    check("mul_busy_done", 32'(busy), 32'd0);
    expect_now("mul_10_20", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mul_done_in_ready", 32'(in_ready), 32'd1);
    send(MUL, 8'h0D, 8'h0B);
    while (!out_valid && k < 60) begin @(posedge clk); #1; k++; end
    expect_now("mul_0d_0b", 8'h8F, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back single-cycle ops.
    c0 = cyc;
    send(ADD, 8'h12, 8'h34);
    send(XOR, 8'hF0, 8'hFF);
    send(OR,  8'h40, 8'h02);
    check("b2b_cycles", 32'(cyc - c0), 32'd3);
    expect_now("b2b_or", 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);

    // Consumer stall with a pending request.
    out_ready = 1'b0;
    snap = {result, Z, C, V, N_flag};
    operation = XOR; SrcA = 8'h3C; SrcB = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_hold", 32'({result, Z, C, V, N_flag}), 32'(snap));
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_resume_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_now("stall_xor", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (N + 4) @(posedge clk); #1;
    check("sb_drained_random", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a multiply.
    send(MUL, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({out_valid, busy, result, Z, C, V, N_flag}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      stale += int'(out_valid);
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    send(SUB, 8'h80, 8'h01);
    expect_now("post_rst_sub", 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("sb_drained_final", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Width-parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Adds XOR, logical shifts and an iterative unsigned multiply to the operation set.
- Computes true carry and signed-overflow flags and registers all results and flags.
- Sits between the datapath register file and the writeback stage; the valid/ready handshake lets the multi-cycle multiply stall the producer.

Parameters:
- N, 8, operand/result width in bits, N >= 2.
- SHW, $clog2(N), width of the shift-amount field taken from SrcB[SHW-1:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  SrcA, SrcB and operation are valid this cycle.
- in_ready  out  1  block accepts an operation this cycle.
- SrcA  in  N  operand A.
- SrcB  in  N  operand B; SrcB[SHW-1:0] is the shift amount for shifts.
- operation  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LSL, 110 LSR, 111 MUL.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  N  registered result.
- Z  out  1  registered zero flag.
- C  out  1  registered carry flag.
- V  out  1  registered signed-overflow flag.
- N_flag  out  1  registered negative flag, equal to result[N-1].
- busy  out  1  high while a MUL iterates.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid, busy, result, Z, C, V, N_flag all go to 0.
  - Iteration counter and internal product/operand registers clear.
- Handshake:
  - An operation is accepted when in_valid & in_ready are both high at a clock edge.
  - in_ready = (state==IDLE) & (!out_valid | out_ready). This is combinational from state, out_valid and out_ready only; it never depends on in_valid.
  - The result is transferred when out_valid & out_ready are both high at an edge.
  - While out_valid=1 and out_ready=0, result and all flags hold stable.
- State machine:
  - IDLE:
    - Accepting a non-MUL op registers its result and flags, and out_valid=1 after that edge. Latency is 1 cycle; back-to-back acceptance gives one result per cycle.
    - Accepting a MUL latches SrcA, SrcB and clears the product accumulator and counter. State goes to MUL, busy=1, and out_valid clears at that edge if the prior result was taken.
  - MUL:
    - One shift-add step per cycle, with a 2N-bit accumulator.
    - On the Nth step edge: result = product[N-1:0], out_valid=1, busy=0, state goes to IDLE.
    - Total latency is N+1 cycles from the accept edge to out_valid.
  - in_valid is ignored outside IDLE (in_ready=0).
- Arithmetic and flags:
  - ADD: (N+1)-bit sum. C = carry out. V = (A[N-1]==B[N-1]) & (sum[N-1]!=A[N-1]).
  - SUB: computed as A + ~B + 1. C = carry out, i.e. 1 when there is no borrow (A >= B unsigned). V = (A[N-1]!=B[N-1]) & (diff[N-1]!=A[N-1]).
  - AND, OR, XOR: C=0, V=0.
  - LSL and LSR: logical shift by SrcB[SHW-1:0]. Amount 0 gives result=A and C=0. Otherwise C = last bit shifted out. V=0.
  - MUL: unsigned product. C = 1 if product[2N-1:N] != 0. V=0.
  - All ops: Z = (result==0), N_flag = result[N-1].
  - All wrap-around is modulo 2^N.
- Boundaries:
  - out_ready=1 during the cycle a MUL completes: the next op can be accepted on the edge after out_valid rises.
  - Reset asserted mid-MUL aborts the multiply; no result is produced.
  - An output held while out_ready=0 blocks all acceptance.

Test Plan:
- Reset then N=8: ADD 0x7F+0x01 -> result 0x80, V=1, C=0, N_flag=1, Z=0, out_valid one cycle after accept.
- SUB 0x05-0x05 -> result 0x00, Z=1, C=1, V=0. SUB 0x03-0x05 -> 0xFE, C=0, N_flag=1.
- ADD 0xFF+0x01 -> result 0x00, C=1, Z=1, V=0. LSL 0x81 by 1 -> 0x02, C=1. LSR 0x01 by 1 -> 0x00, C=1, Z=1.
- MUL 0x10*0x20 -> result 0x00, C=1, Z=1, busy high for 8 cycles, out_valid 9 cycles after accept, in_ready=0 throughout.
- Back-to-back ADD/XOR/OR with out_ready=1 -> one result per cycle. Drop out_ready for 3 cycles -> result and flags stable, in_ready=0, no operations lost.
- Assert rst_n=0 at MUL cycle 4 -> all outputs 0 immediately. After release, in_ready=1 and no stale result appears.
